io_bus_bridge: RTL
==================

// Module: io_bus_bridge
// PURPOSE
//  CPU-side master for the peripheral bus: takes a single CPU I/O load/store request and registers it.
//  Drives the periph bus select/read/write strobes and holds them until the addressed peripheral returns ready.
//  Returns read data plus a one-cycle ack to the CPU, with wait states inserted while busy.
//  A watchdog counter ends any access whose peripheral never returns ready and reports it as an error.
// PARAMETERS
//  TMO_CYCLES  255      max cycles in ACCESS before forced error completion (1..2^TMO_W-1)
//  TMO_W       8        width of timeout counter
//  ERR_RDATA   16'hDEAD value returned on o_cpu_rdata for a timed-out read
// PORTS
//  i_clk        in   1   clock; all logic on rising edge
//  i_rst        in   1   synchronous reset, active-low
//  i_cpu_req    in   1   CPU access request; sampled only in IDLE
//  i_cpu_we     in   1   1=store, 0=load; sampled with i_cpu_req
//  i_cpu_addr   in   16  I/O address; sampled with i_cpu_req
//  i_cpu_wdata  in   16  store data; sampled with i_cpu_req
//  o_cpu_busy   out  1   1 whenever state != IDLE; CPU stalls on it
//  o_cpu_ack    out  1   one-cycle completion pulse (RESP state)
//  o_cpu_err    out  1   valid with o_cpu_ack; 1 = access timed out
//  o_cpu_rdata  out  16  load data, valid with o_cpu_ack; 0 on store ack
//  o_addr       out  16  to periph bus i_addr
//  o_sel        out  1   to periph bus i_sel
//  o_we         out  1   to periph bus i_we
//  o_re         out  1   to periph bus i_re
//  o_wdata      out  16  to periph bus i_wdata
//  i_rdata      in   16  from periph bus o_rdata
//  i_rdy        in   1   from periph bus o_rdy
//  i_err_clr    in   1   clears sticky error status
//  o_err_flag   out  1   sticky: set on any timeout
//  o_err_addr   out  16  address of most recent timed-out access
// BEHAVIOUR
//  - Reset (i_rst=0 at clock edge): state=IDLE.
//    All outputs 0: busy, ack, err, rdata, addr, sel, we, re, wdata, err_flag, err_addr. Timeout counter=0.
//  - Reset has priority over everything.
//    Reset during ACCESS drops o_sel/o_we/o_re at that edge; no ack is issued.
//  - All outputs are registered; no combinational path from any input to any output.
//  - States: IDLE -> ACCESS -> RESP -> IDLE.
//  - IDLE: if i_cpu_req=1, latch addr/we/wdata into o_addr/o_we/o_wdata, set o_re=~we, o_sel=1, counter=0.
//    Next state is ACCESS. i_cpu_req=0 stays in IDLE.
//  - ACCESS: o_sel/o_we/o_re/o_addr/o_wdata held stable; counter increments each cycle.
//    - i_rdy=1: capture i_rdata if load (0 if store), err=0, go RESP.
//    - else if counter==TMO_CYCLES-1: rdata=ERR_RDATA if load (0 if store), err=1, set o_err_flag, o_err_addr=o_addr, go RESP.
//    - i_rdy=1 in the same cycle as the timeout condition: i_rdy wins, normal completion.
//  - On leaving ACCESS, o_sel/o_we/o_re clear, so strobes are high for exactly the ACCESS cycles.
//  - RESP: o_cpu_ack=1 for exactly one cycle; o_cpu_rdata/o_cpu_err valid in that cycle; next state IDLE.
//    o_cpu_rdata holds its value until the next ack.
//  - Latency: request at edge N gives ACCESS in cycle N+1.
//    With i_rdy=1 immediately, ack is in cycle N+2; each extra wait cycle adds 1.
//  - o_cpu_busy=1 in ACCESS and RESP, so back-to-back requests have a minimum 3-cycle period.
//  - i_cpu_req in ACCESS or RESP is ignored, not queued.
//  - i_err_clr=1 clears o_err_flag (o_err_addr kept).
//    If a timeout occurs in the same cycle, set wins: flag=1 and addr is updated.
// TESTING
//  1. Load: req, addr=16'h0F02, i_rdy=1 always, i_rdata=16'h1234 -> o_re=o_sel=1 one cycle; ack 2 cycles after req; rdata=16'h1234; err=0.
//  2. Store with wait: req, we=1, addr=16'h0300, wdata=16'h00A5, i_rdy low 3 ACCESS cycles -> o_we high 4 cycles, o_wdata=16'h00A5 stable, ack cycle 6, rdata=0.
//  3. Timeout: TMO_CYCLES=4, load addr=16'h0400, i_rdy=0 -> ack at cycle 6, err=1, rdata=16'hDEAD, err_flag=1, err_addr=16'h0400; then i_err_clr -> flag=0.
//  4. Race: i_rdy=1 exactly on last timeout cycle -> err=0, real rdata, err_flag unchanged; separately err_clr coincident with a new timeout -> flag stays 1.
//  5. Busy: second req with addr=16'h0100 held during ACCESS/RESP of first -> no extra access; a new one starts only once IDLE is sampled.
//  6. Reset mid-ACCESS: i_rst=0 with i_rdy=0 -> next edge sel/we/re/busy=0, no ack; a following request completes normally.

Source files
------------

// File: rtl/io_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_bridge
//  Description : CPU-side master for the peripheral bus. Registers one CPU
//                I/O load/store request, drives the peripheral select and
//                strobes until the peripheral answers ready (or the watchdog
//                expires), then returns data plus a one-cycle ack.
//  Ports       :
//    i_clk, i_rst                  clock, synchronous active-low reset
//    i_cpu_req/we/addr/wdata       CPU request, sampled only in IDLE
//    o_cpu_busy/ack/err/rdata      CPU stall, completion pulse, status, data
//    o_addr/sel/we/re/wdata        peripheral bus request side
//    i_rdata, i_rdy                peripheral bus response side
//    i_err_clr                     clears the sticky timeout flag
//    o_err_flag, o_err_addr        sticky timeout flag, last timed-out addr
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_bridge #(
    parameter int          TMO_CYCLES = 255,
    parameter int          TMO_W      = 8,
    parameter logic [15:0] ERR_RDATA  = 16'hDEAD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    output logic        o_cpu_busy,
    output logic        o_cpu_ack,
    output logic        o_cpu_err,
    output logic [15:0] o_cpu_rdata,
    output logic [15:0] o_addr,
    output logic        o_sel,
    output logic        o_we,
    output logic        o_re,
    output logic [15:0] o_wdata,
    input  logic [15:0] i_rdata,
    input  logic        i_rdy,
    input  logic        i_err_clr,
    output logic        o_err_flag,
    output logic [15:0] o_err_addr
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    // Counter starts at 0 on the first ACCESS cycle, so comparing against
    // TMO_CYCLES-1 allows exactly TMO_CYCLES cycles in ACCESS.
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] c_CNT_ONE  = TMO_W'(1);

    logic [1:0]       r_state,     w_state_nxt;
    logic [TMO_W-1:0] r_tmo_cnt,   w_tmo_cnt_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_ack,       w_ack_nxt;
    logic             r_err,       w_err_nxt;
    logic [15:0]      r_rdata,     w_rdata_nxt;
    logic [15:0]      r_addr,      w_addr_nxt;
    logic             r_sel,       w_sel_nxt;
    logic             r_we,        w_we_nxt;
    logic             r_re,        w_re_nxt;
    logic [15:0]      r_wdata,     w_wdata_nxt;
    logic             r_err_flag,  w_err_flag_nxt;
    logic [15:0]      r_err_addr,  w_err_addr_nxt;

    // Next-state and next-output logic; every output is the registered copy
    // of these values, so no input reaches an output combinationally.
    always_comb begin
        w_state_nxt    = r_state;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_ack_nxt      = 1'b0;
        w_err_nxt      = r_err;
        w_rdata_nxt    = r_rdata;
        w_addr_nxt     = r_addr;
        w_sel_nxt      = r_sel;
        w_we_nxt       = r_we;
        w_re_nxt       = r_re;
        w_wdata_nxt    = r_wdata;
        w_err_flag_nxt = r_err_flag;
        w_err_addr_nxt = r_err_addr;

        // Clear first so a timeout later in this block overrides it.
        if (i_err_clr) begin
            w_err_flag_nxt = 1'b0;
        end

        case (r_state)
            c_ST_IDLE: begin
                if (i_cpu_req) begin
                    w_addr_nxt    = i_cpu_addr;
                    w_we_nxt      = i_cpu_we;
                    w_re_nxt      = ~i_cpu_we;
                    w_wdata_nxt   = i_cpu_wdata;
                    w_sel_nxt     = 1'b1;
                    w_tmo_cnt_nxt = '0;
                    w_state_nxt   = c_ST_ACCESS;
                end
            end

            c_ST_ACCESS: begin
                w_tmo_cnt_nxt = r_tmo_cnt + c_CNT_ONE;
                // Ready is tested first so it wins over a coincident timeout.
                if (i_rdy) begin
                    w_rdata_nxt = r_we ? 16'h0000 : i_rdata;
                    w_err_nxt   = 1'b0;
                    w_sel_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_re_nxt    = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_rdata_nxt    = r_we ? 16'h0000 : ERR_RDATA;
                    w_err_nxt      = 1'b1;
                    w_err_flag_nxt = 1'b1;
                    w_err_addr_nxt = r_addr;
                    w_sel_nxt      = 1'b0;
                    w_we_nxt       = 1'b0;
                    w_re_nxt       = 1'b0;
                    w_ack_nxt      = 1'b1;
                    w_state_nxt    = c_ST_RESP;
                end
            end

            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_sel_nxt   = 1'b0;
                w_we_nxt    = 1'b0;
                w_re_nxt    = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= c_ST_IDLE;
            r_tmo_cnt  <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 16'h0000;
            r_addr     <= 16'h0000;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_wdata    <= 16'h0000;
            r_err_flag <= 1'b0;
            r_err_addr <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_addr     <= w_addr_nxt;
            r_sel      <= w_sel_nxt;
            r_we       <= w_we_nxt;
            r_re       <= w_re_nxt;
            r_wdata    <= w_wdata_nxt;
            r_err_flag <= w_err_flag_nxt;
            r_err_addr <= w_err_addr_nxt;
        end
    end

    assign o_cpu_busy  = r_busy;
    assign o_cpu_ack   = r_ack;
    assign o_cpu_err   = r_err;
    assign o_cpu_rdata = r_rdata;
    assign o_addr      = r_addr;
    assign o_sel       = r_sel;
    assign o_we        = r_we;
    assign o_re        = r_re;
    assign o_wdata     = r_wdata;
    assign o_err_flag  = r_err_flag;
    assign o_err_addr  = r_err_addr;

endmodule
`default_nettype wire
